// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus between the fetch/PC unit and instruction memory.
//   req   : fetch request, held high until ack
//   addr  : fetch address, stable while req is high
//   ack   : memory returns the word this cycle
//   rdata : instruction word, valid when req & ack
// master = fetch unit, slave = instruction memory.
interface fetch_pc_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter and instruction-fetch stage. Holds the PC, fetches one word
// over the imem bus, presents it to decode/execute, and on commit computes the
// next PC from the decoder controls plus the ALU zero flag. One instruction is
// in flight at a time.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pc_op_i         : 00 seq, 01 beq, 10 bne, 11 reserved (treated as seq)
//   jump_i, jr_i    : j/jal and register jump
//   alu_zero_i      : ALU zero flag of the current instruction
//   imm_sext_i      : sign-extended branch offset in words
//   jtarget_i       : instr[25:0] jump target
//   jr_addr_i       : rs value for jr
//   commit_i        : datapath finished the current instruction
//   imem            : fetch bus (master side)
//   instr_o         : latched instruction, instr_valid_o while executing
//   pc_o            : address of current instruction, link_addr_o = pc + 4
//   misalign_o      : one-cycle pulse after a jr commit with jr_addr[1:0] != 0
//   retired_o       : count of committed instructions (wraps)
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pc_op_i,
    input  logic               jump_i,
    input  logic               jr_i,
    input  logic               alu_zero_i,
    input  logic [31:0]        imm_sext_i,
    input  logic [25:0]        jtarget_i,
    input  logic [31:0]        jr_addr_i,
    input  logic               commit_i,
    fetch_pc_unit_if.master    imem,
    output logic [31:0]        instr_o,
    output logic               instr_valid_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        link_addr_o,
    output logic               misalign_o,
    output logic [31:0]        retired_o
);

    typedef enum logic [1:0] {StIdle, StReq, StExec} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        misalign_q, misalign_d;

    logic [31:0] link_addr;
    logic [31:0] branch_tgt;
    logic [31:0] next_pc;

    assign link_addr  = pc_q + 32'd4;
    assign branch_tgt = link_addr + {imm_sext_i[29:0], 2'b00};

    always_comb begin
        next_pc = link_addr;
        if (jr_i) begin
            next_pc = {jr_addr_i[31:2], 2'b00};
        end else if (jump_i) begin
            next_pc = {link_addr[31:28], jtarget_i, 2'b00};
        end else if (pc_op_i == 2'b01 && alu_zero_i) begin
            next_pc = branch_tgt;
        end else if (pc_op_i == 2'b10 && !alu_zero_i) begin
            next_pc = branch_tgt;
        end
    end

    // Ack outside StReq and commit outside StExec fall through untouched.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        misalign_d = 1'b0;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem.ack) begin
                    instr_d = imem.rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (commit_i) begin
                    pc_d       = next_pc;
                    retired_d  = retired_q + 32'd1;
                    misalign_d = jr_i && (jr_addr_i[1:0] != 2'b00);
                    state_d    = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            retired_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem.req      = (state_q == StReq);
    assign imem.addr     = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == StExec);
    assign pc_o          = pc_q;
    assign link_addr_o   = link_addr;
    assign misalign_o    = misalign_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: expected fetch addresses are queued when a commit
// is driven and popped when the unit raises its next fetch request.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_op;
    logic        jump;
    logic        jr;
    logic        alu_zero;
    logic [31:0] imm_sext;
    logic [25:0] jtarget;
    logic [31:0] jr_addr;
    logic        commit;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        misalign;
    logic [31:0] retired;

    fetch_pc_unit_if imem_bus ();

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_op_i       (pc_op),
        .jump_i        (jump),
        .jr_i          (jr),
        .alu_zero_i    (alu_zero),
        .imm_sext_i    (imm_sext),
        .jtarget_i     (jtarget),
        .jr_addr_i     (jr_addr),
        .commit_i      (commit),
        .imem          (imem_bus),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .pc_o          (pc),
        .link_addr_o   (link_addr),
        .misalign_o    (misalign),
        .retired_o     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_retired;

    function automatic logic [31:0] calc_next(input logic [31:0] p, input logic [1:0] op,
                                              input logic j, input logic r, input logic z,
                                              input logic [31:0] imm, input logic [25:0] jt,
                                              input logic [31:0] jra);
        logic [31:0] lnk;
        lnk = p + 32'd4;
        if (r)                    return {jra[31:2], 2'b00};
        if (j)                    return {lnk[31:28], jt, 2'b00};
        if (op == 2'b01 && z)     return lnk + (imm << 2);
        if (op == 2'b10 && !z)    return lnk + (imm << 2);
        return lnk;
    endfunction

    task automatic clear_ctrl();
        pc_op = 2'b00; jump = 1'b0; jr = 1'b0; alu_zero = 1'b0;
        imm_sext = 32'h0; jtarget = 26'h0; jr_addr = 32'h0; commit = 1'b0;
    endtask

    // Wait for a request, pop the expected address, hold ack off for 'delay'
    // cycles, then return 'word' and check it is presented for execute.
    task automatic fetch(input logic [31:0] word, input int delay);
        logic [31:0] exp_a;
        int waited;
        waited = 0;
        while (imem_bus.req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (imem_bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_req_timeout: req=%b required 1", imem_bus.req);
            return;
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL fetch_queue_empty: addr=%h with nothing expected", imem_bus.addr);
            exp_a = model_pc;
        end else begin
            exp_a = exp_q.pop_front();
            if (imem_bus.addr !== exp_a) begin
                n_fail++;
                $display("FAIL fetch_addr: addr=%h required %h", imem_bus.addr, exp_a);
            end
        end
        model_pc = exp_a;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            n_cmp++;
            if (imem_bus.req !== 1'b1 || imem_bus.addr !== exp_a) begin
                n_fail++;
                $display("FAIL fetch_hold: req=%b addr=%h required 1 %h",
                         imem_bus.req, imem_bus.addr, exp_a);
            end
        end
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = word;
        @(negedge clk);
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'h0;
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== word || imem_bus.req !== 1'b0 || pc !== exp_a) begin
            n_fail++;
            $display("FAIL fetch_present: valid=%b instr=%h req=%b pc=%h required 1 %h 0 %h",
                     instr_valid, instr, imem_bus.req, pc, word, exp_a);
        end
    endtask

    // Commit the current instruction with the given controls; leaves the unit in REQ.
    task automatic do_commit(input logic [1:0] op, input logic j, input logic r, input logic z,
                             input logic [31:0] imm, input logic [25:0] jt,
                             input logic [31:0] jra);
        logic [31:0] nxt;
        logic        exp_mis;
        nxt     = calc_next(model_pc, op, j, r, z, imm, jt, jra);
        exp_mis = r && (jra[1:0] != 2'b00);
        n_cmp++;
        if (link_addr !== model_pc + 32'd4) begin
            n_fail++;
            $display("FAIL link_addr: link=%h required %h", link_addr, model_pc + 32'd4);
        end
        pc_op = op; jump = j; jr = r; alu_zero = z;
        imm_sext = imm; jtarget = jt; jr_addr = jra; commit = 1'b1;
        @(negedge clk);
        clear_ctrl();
        model_retired = model_retired + 32'd1;
        exp_q.push_back(nxt);
        n_cmp++;
        if (misalign !== exp_mis || retired !== model_retired || instr_valid !== 1'b0 ||
            imem_bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL commit: misalign=%b retired=%h valid=%b req=%b required %b %h 0 1",
                     misalign, retired, instr_valid, imem_bus.req, exp_mis, model_retired);
        end
    endtask

    task automatic goto(input logic [31:0] a);
        do_commit(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 26'h0, a);
        fetch(32'h0000_0000, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_bus.ack = 1'b0;
        clear_ctrl();
        @(negedge clk);
        n_cmp++;
        if (pc !== 32'h0 || instr !== 32'h0 || retired !== 32'h0 || misalign !== 1'b0 ||
            imem_bus.req !== 1'b0 || instr_valid !== 1'b0 || link_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h instr=%h ret=%h mis=%b req=%b valid=%b link=%h",
                     pc, instr, retired, misalign, imem_bus.req, instr_valid, link_addr);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        model_retired = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (imem_bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_latency: req=%b required 1", imem_bus.req);
        end
        fetch(32'h2008_0005, 2);
    endtask

    task automatic test_branch();
        goto(32'h10);
        do_commit(2'b01, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 26'h0, 32'h0);
        fetch(32'h1000_FFFF, 1);
        goto(32'h10);
        do_commit(2'b01, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 26'h0, 32'h0);
        fetch(32'h1400_0002, 0);
        do_commit(2'b10, 1'b0, 1'b0, 1'b0, 32'h2, 26'h0, 32'h0);
        fetch(32'h0000_0020, 0);
        do_commit(2'b10, 1'b0, 1'b0, 1'b1, 32'h2, 26'h0, 32'h0);
        fetch(32'h0000_0024, 0);
        do_commit(2'b11, 1'b0, 1'b0, 1'b1, 32'h8, 26'h0, 32'h0);
        fetch(32'h0000_0028, 0);
    endtask

    task automatic test_jump();
        goto(32'h1000_0040);
        n_cmp++;
        if (link_addr !== 32'h1000_0044) begin
            n_fail++;
            $display("FAIL jump_link: link=%h required 10000044", link_addr);
        end
        do_commit(2'b01, 1'b1, 1'b0, 1'b1, 32'h40, 26'h000_0100, 32'h0);
        fetch(32'h0800_0100, 0);
    endtask

    task automatic test_jr_misalign();
        do_commit(2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 26'h3FF_FFFF, 32'h0000_0103);
        @(negedge clk);
        n_cmp++;
        if (misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_one_cycle: misalign=%b required 0", misalign);
        end
        fetch(32'h0000_0008, 0);
    endtask

    task automatic test_wrap();
        goto(32'hFFFF_FFFC);
        do_commit(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
        fetch(32'h0000_0000, 0);
    endtask

    task automatic test_ignored();
        logic [31:0] hold_pc;
        hold_pc = pc;
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        imem_bus.ack = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 32'h0 || pc !== hold_pc || imem_bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack_exec: valid=%b instr=%h pc=%h required 1 0 %h",
                     instr_valid, instr, pc, hold_pc);
        end
        do_commit(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
        jump = 1'b1;
        jtarget = 26'h123_4567;
        commit = 1'b1;
        @(negedge clk);
        clear_ctrl();
        n_cmp++;
        if (pc !== exp_q[0] || retired !== model_retired || imem_bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_commit_req: pc=%h retired=%h req=%b required %h %h 1",
                     pc, retired, imem_bus.req, exp_q[0], model_retired);
        end
        rst = 1'b1;
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0;
        imem_bus.ack = 1'b0;
        imem_bus.rdata = 32'h0;
        n_cmp++;
        if (imem_bus.req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            pc !== 32'h0 || retired !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wins: req=%b valid=%b instr=%h pc=%h ret=%h required 0 0 0 0 0",
                     imem_bus.req, instr_valid, instr, pc, retired);
        end
        exp_q.delete();
        exp_q.push_back(32'h0);
        model_retired = 32'h0;
        fetch(32'h2008_0005, 0);
    endtask

    initial begin
        rst = 1'b1;
        imem_bus.ack = 1'b0;
        imem_bus.rdata = 32'h0;
        clear_ctrl();
        model_pc = 32'h0;
        model_retired = 32'h0;
        test_reset();
        test_branch();
        test_jump();
        test_jr_misalign();
        test_wrap();
        test_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
